// File: rtl/johnson_decoder_checker.sv
// -----------------------------------------------------------------------------
// johnson_decoder_checker
//
// Decodes an N-bit Johnson (twisted-ring) code stream into a phase index and
// checks that successive samples follow the legal Johnson sequence. A small
// FSM (UNLOCKED -> LOCKING -> LOCKED) declares lock after LOCK_CNT consecutive
// in-sequence legal samples. Illegal codes and out-of-sequence codes seen
// while locked are counted in a saturating 8-bit error counter.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   code_in      Johnson code sample, bit N-1 is the MSB
//   code_valid   code_in is sampled only when high
//   clr_err      synchronous clear of err_cnt (wins over a same-cycle event)
//   phase        decoded phase of the last legal sample
//   phase_valid  one-cycle pulse, phase was loaded from a legal sample
//   illegal      one-cycle pulse, sampled code is not a Johnson code
//   seq_err      one-cycle pulse, legal but not the successor while locked
//   locked       high while the FSM is in LOCKED
//   err_cnt      saturating count of illegal plus seq_err events
//
// All outputs are registered: a sample taken at edge k is reflected in the
// outputs right after edge k.
// -----------------------------------------------------------------------------
module johnson_decoder_checker #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            code_in,
  input  logic                    code_valid,
  input  logic                    clr_err,
  output logic [$clog2(2*N)-1:0]  phase,
  output logic                    phase_valid,
  output logic                    illegal,
  output logic                    seq_err,
  output logic                    locked,
  output logic [7:0]              err_cnt
);

  localparam int PW = $clog2(2*N);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKING  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [PW-1:0] LAST_PHASE  = PW'(2*N-1);
  localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_CNT);

  // Returns {legal, phase}. Phase p in 0..N has the top p bits set; phase
  // p in N+1..2N-1 has the low 2N-p bits set. Anything else is illegal.
  function automatic logic [PW:0] johnson_decode(input logic [N-1:0] code);
    logic [N-1:0] pattern;
    logic [PW:0]  result;
    result = {(PW+1){1'b0}};
    for (int p = 0; p < 2*N; p++) begin
      for (int b = 0; b < N; b++) begin
        pattern[b] = (p <= N) ? (b >= N - p) : (b < 2*N - p);
      end
      if (code == pattern) begin
        result = {1'b1, PW'(p)};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  logic [1:0]    state_r;
  logic [3:0]    match_r;
  logic [PW-1:0] phase_r;
  logic          phase_valid_r;
  logic          illegal_r;
  logic          seq_err_r;
  logic          locked_r;
  logic [7:0]    err_cnt_r;

  logic [PW:0]   decode_s;
  logic          legal_s;
  logic [PW-1:0] dec_phase_s;
  logic [PW-1:0] succ_phase_s;
  logic          is_succ_s;

  logic [1:0]    state_s;
  logic [3:0]    match_s;
  logic [PW-1:0] phase_s;
  logic          phase_valid_s;
  logic          illegal_s;
  logic          seq_err_s;
  logic [7:0]    err_cnt_s;

  // Decode the incoming sample and work out the expected successor phase.
  always_comb begin
    decode_s     = johnson_decode(code_in);
    legal_s      = decode_s[PW];
    dec_phase_s  = decode_s[PW-1:0];
    succ_phase_s = (phase_r == LAST_PHASE) ? {PW{1'b0}}
                                           : phase_r + {{(PW-1){1'b0}}, 1'b1};
    is_succ_s    = (dec_phase_s == succ_phase_s);
  end

  // Next-state logic for the lock FSM, phase register and event pulses.
  always_comb begin
    state_s       = state_r;
    match_s       = match_r;
    phase_s       = phase_r;
    phase_valid_s = 1'b0;
    illegal_s     = 1'b0;
    seq_err_s     = 1'b0;
    if (code_valid) begin
      if (legal_s) begin
        phase_s       = dec_phase_s;
        phase_valid_s = 1'b1;
        case (state_r)
          ST_UNLOCKED: begin
            // Any legal code starts a new run; the stored phase is not trusted.
            state_s = (LOCK_TARGET == 4'd1) ? ST_LOCKED : ST_LOCKING;
            match_s = 4'd1;
          end
          ST_LOCKING: begin
            if (is_succ_s) begin
              if ((match_r + 4'd1) >= LOCK_TARGET) begin
                state_s = ST_LOCKED;
                match_s = LOCK_TARGET;
              end else begin
                state_s = ST_LOCKING;
                match_s = match_r + 4'd1;
              end
            end else begin
              state_s = ST_LOCKING;
              match_s = 4'd1;
            end
          end
          ST_LOCKED: begin
            if (is_succ_s) begin
              state_s = ST_LOCKED;
              match_s = match_r;
            end else begin
              // The out-of-sequence code itself counts as the first of a new run.
              seq_err_s = 1'b1;
              state_s   = ST_LOCKING;
              match_s   = 4'd1;
            end
          end
          default: begin
            state_s = ST_UNLOCKED;
            match_s = 4'd0;
          end
        endcase
      end else begin
        illegal_s = 1'b1;
        state_s   = ST_UNLOCKED;
        match_s   = 4'd0;
      end
    end else begin
      state_s = state_r;
    end
  end

  // Saturating error counter; a same-cycle clear wins over an event.
  always_comb begin
    err_cnt_s = err_cnt_r;
    if (clr_err) begin
      err_cnt_s = 8'd0;
    end else if ((illegal_s || seq_err_s) && (err_cnt_r != 8'd255)) begin
      err_cnt_s = err_cnt_r + 8'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_UNLOCKED;
      match_r       <= 4'd0;
      phase_r       <= {PW{1'b0}};
      phase_valid_r <= 1'b0;
      illegal_r     <= 1'b0;
      seq_err_r     <= 1'b0;
      locked_r      <= 1'b0;
      err_cnt_r     <= 8'd0;
    end else begin
      state_r       <= state_s;
      match_r       <= match_s;
      phase_r       <= phase_s;
      phase_valid_r <= phase_valid_s;
      illegal_r     <= illegal_s;
      seq_err_r     <= seq_err_s;
      locked_r      <= (state_s == ST_LOCKED);
      err_cnt_r     <= err_cnt_s;
    end
  end

  assign phase       = phase_r;
  assign phase_valid = phase_valid_r;
  assign illegal     = illegal_r;
  assign seq_err     = seq_err_r;
  assign locked      = locked_r;
  assign err_cnt     = err_cnt_r;

endmodule
